serial_addsub: RTL and testbench

Bit-serial add/subtract engine that drives one fas cell, LSB first, one bit per clock. The block holds the operand shift registers, the carry/borrow flop, the bit counter and the control FSM. Each cycle it feeds the fas inputs a, b, cin and a_ns, and registers the s and cout outputs. It is the sequential datapath stage that consumes fas results and produces WIDTH-bit add/sub results for the rest of the ALU.

---
 rtl/addsub_pkg.sv | 17 +
 rtl/fas.sv | 25 ++
 rtl/serial_addsub.sv | 123 ++++++++++++
 tb/tb_serial_addsub.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the bit-serial add/subtract datapath.
//   addsub_state_t : control FSM encoding (IDLE, RUN, DONE)
//   FAS_TPD_MAX    : worst-case fas combinational path, in time units
//   MODE_ADD/SUB   : encoding of the a_ns mode bit
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } addsub_state_t;

  localparam int   FAS_TPD_MAX = 28;
  localparam logic MODE_ADD    = 1'b1;
  localparam logic MODE_SUB    = 1'b0;

endpackage

// File: rtl/fas.sv
// Single-bit full adder / full subtractor cell.
//   a, b  : operand bits
//   cin   : carry in (add) or borrow in (subtract)
//   a_ns  : 1 = add, 0 = subtract
//   s     : sum / difference bit
//   cout  : carry out (add) or borrow out (subtract)
module fas
  import addsub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic a_ns,
  output logic s,
  output logic cout
);

  logic w_a_eff;

  // Borrow out is maj(~a, b, bin); carry out is maj(a, b, cin).
  assign w_a_eff = (a_ns == MODE_ADD) ? a : ~a;
  assign s       = a ^ b ^ cin;
  assign cout    = (w_a_eff & b) | (w_a_eff & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract engine: one fas cell, LSB first, one bit per clock.
//   clk       : clock
//   rst       : asynchronous active-high reset
//   start     : operation request, sampled in IDLE or DONE
//   a_ns      : 1 = a+b, 0 = a-b (latched on accepted start)
//   a, b      : operands (latched on accepted start)
//   busy      : high while the operation is running
//   done      : one-cycle pulse when result/carry_out/overflow update
//   result    : sum or difference, held until the next done
//   carry_out : final carry (add) or final borrow (subtract)
//   overflow  : two's-complement signed overflow
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             a_ns,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  addsub_state_t    r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_s_sr;
  logic             r_mode;
  logic             r_cy;
  logic             r_cy_msb;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_carry_out;
  logic             r_overflow;

  logic             w_s;
  logic             w_cout;

  fas u_fas (
    .a    (r_a_sr[0]),
    .b    (r_b_sr[0]),
    .cin  (r_cy),
    .a_ns (r_mode),
    .s    (w_s),
    .cout (w_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a_sr      <= '0;
      r_b_sr      <= '0;
      r_s_sr      <= '0;
      r_mode      <= 1'b0;
      r_cy        <= 1'b0;
      r_cy_msb    <= 1'b0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE, DONE: begin
          r_busy <= 1'b0;
          if (start) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_mode  <= a_ns;
            r_cy    <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_a_sr <= r_a_sr >> 1;
          r_b_sr <= r_b_sr >> 1;
          r_s_sr <= {w_s, r_s_sr[WIDTH-1:1]};
          r_cy   <= w_cout;
          r_cnt  <= r_cnt + CNT_W'(1);
          // Carry into the MSB, kept for the signed overflow test.
          if (r_cnt == CNT_W'(WIDTH - 2)) begin
            r_cy_msb <= w_cout;
          end
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_result    <= {w_s, r_s_sr[WIDTH-1:1]};
            r_carry_out <= w_cout;
            r_overflow  <= r_cy_msb ^ w_cout;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;
  import addsub_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #20 clk = ~clk;

  // WIDTH=8 instance
  logic        st8 = 1'b0, ns8 = 1'b1;
  logic [7:0]  a8 = '0, b8 = '0, res8;
  logic        busy8, done8, co8, ov8;
  // WIDTH=16 instance
  logic        st16 = 1'b0, ns16 = 1'b1;
  logic [15:0] a16 = '0, b16 = '0, res16;
  logic        busy16, done16, co16, ov16;

  serial_addsub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(st8), .a_ns(ns8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(res8), .carry_out(co8), .overflow(ov8)
  );

  serial_addsub #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(st16), .a_ns(ns16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .result(res16), .carry_out(co16), .overflow(ov16)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       mode;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic       co;
    logic       ov;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic get_out(input int w, output logic [31:0] r, output logic co,
                         output logic ov, output logic bz, output logic dn);
    if (w == 8) begin
      r = {24'b0, res8}; co = co8; ov = ov8; bz = busy8; dn = done8;
    end else begin
      r = {16'b0, res16}; co = co16; ov = ov16; bz = busy16; dn = done16;
    end
  endtask

  // Drives a start pulse; returns at the negedge right after the accepting edge.
  task automatic start_op(input int w, input logic mode, input logic [31:0] av,
                          input logic [31:0] bv);
    @(negedge clk);
    if (w == 8) begin
      a8 = av[7:0]; b8 = bv[7:0]; ns8 = mode; st8 = 1'b1;
    end else begin
      a16 = av[15:0]; b16 = bv[15:0]; ns16 = mode; st16 = 1'b1;
    end
    @(negedge clk);
    st8 = 1'b0;
    st16 = 1'b0;
  endtask

  // Waits for done, counting edges since the accepting edge; flags any
  // output change before done and any busy/done overlap.
  task automatic wait_done(input int w, input int lat0, output int lat, output bit ok);
    logic [31:0] r0, r;
    logic co0, ov0, co, ov, bz, dn;
    get_out(w, r0, co0, ov0, bz, dn);
    ok = 1'b1;
    lat = lat0;
    forever begin
      get_out(w, r, co, ov, bz, dn);
      if (bz && dn) ok = 1'b0;
      if (dn) break;
      if (r !== r0 || co !== co0 || ov !== ov0) ok = 1'b0;
      if (lat >= 200) break;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic model(input int w, input logic mode, input logic [31:0] av,
                       input logic [31:0] bv, output logic [31:0] r,
                       output logic co, output logic ov);
    logic [32:0] full;
    logic [31:0] mask;
    logic sa, sb, sr;
    mask = (32'h1 << w) - 32'h1;
    if (mode == MODE_ADD) full = {1'b0, av} + {1'b0, bv};
    else                  full = {1'b0, av} - {1'b0, bv};
    r  = full[31:0] & mask;
    co = (mode == MODE_ADD) ? full[w] : (av < bv);
    sa = av[w-1]; sb = bv[w-1]; sr = r[w-1];
    if (mode == MODE_ADD) ov = (sa == sb) && (sr != sa);
    else                  ov = (sa != sb) && (sr != sa);
  endtask

  task automatic run_check(input int w, input string name, input logic mode,
                           input logic [31:0] av, input logic [31:0] bv,
                           input logic [31:0] er, input logic eco, input logic eov);
    int lat;
    bit ok;
    logic [31:0] r;
    logic co, ov, bz, dn;
    start_op(w, mode, av, bv);
    wait_done(w, 0, lat, ok);
    get_out(w, r, co, ov, bz, dn);
    chk({name, ".result"}, r, er);
    chk({name, ".carry"}, {31'b0, co}, {31'b0, eco});
    chk({name, ".ovf"}, {31'b0, ov}, {31'b0, eov});
    chk({name, ".latency"}, lat, w);
    chk({name, ".stable"}, {31'b0, ok}, 32'd1);
  endtask

  initial begin
    int lat;
    bit ok;
    logic [31:0] r, er, av, bv;
    logic co, ov, bz, dn, eco, eov, mode;

    vecs[0] = '{MODE_ADD, 8'h35, 8'h4A, 8'h7F, 1'b0, 1'b0};
    vecs[1] = '{MODE_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    vecs[2] = '{MODE_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{MODE_SUB, 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0};
    vecs[4] = '{MODE_SUB, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[5] = '{MODE_SUB, 8'h05, 8'h05, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{MODE_ADD, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
    vecs[7] = '{MODE_SUB, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    vecs[8] = '{MODE_SUB, 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    vecs[9] = '{MODE_ADD, 8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    get_out(8, r, co, ov, bz, dn);
    chk("rst8.outs", {r[7:0], co, ov, bz, dn}, 32'd0);
    get_out(16, r, co, ov, bz, dn);
    chk("rst16.outs", {r[15:0], co, ov, bz, dn}, 32'd0);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      run_check(8, $sformatf("vec%0d", i), vecs[i].mode, {24'b0, vecs[i].a},
                {24'b0, vecs[i].b}, {24'b0, vecs[i].r}, vecs[i].co, vecs[i].ov);
    end

    // start during RUN is ignored
    start_op(8, MODE_ADD, 32'h35, 32'h4A);
    @(negedge clk);
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; ns8 = MODE_SUB; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    wait_done(8, 3, lat, ok);
    get_out(8, r, co, ov, bz, dn);
    chk("ignore.result", r, 32'h7F);
    chk("ignore.latency", lat, 8);

    // Back-to-back: start sampled in the DONE cycle
    a8 = 8'h10; b8 = 8'h20; ns8 = MODE_SUB; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    get_out(8, r, co, ov, bz, dn);
    chk("b2b.busy_no_gap", {31'b0, bz}, 32'd1);
    wait_done(8, 0, lat, ok);
    get_out(8, r, co, ov, bz, dn);
    chk("b2b.result", r, 32'hF0);
    chk("b2b.carry", {31'b0, co}, 32'd1);
    chk("b2b.latency", lat, 8);

    // Reset in the middle of RUN
    start_op(8, MODE_ADD, 32'h35, 32'h4A);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    get_out(8, r, co, ov, bz, dn);
    chk("midrst.outs", {r[7:0], co, ov, bz, dn}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 || busy8) ok = 1'b0;
    end
    chk("midrst.no_done", {31'b0, ok}, 32'd1);
    run_check(8, "postrst", MODE_ADD, 32'h01, 32'h01, 32'h02, 1'b0, 1'b0);

    // Random sweep on both widths
    for (int n = 0; n < 1000; n++) begin
      int w;
      w = (n < 500) ? 8 : 16;
      mode = 1'($urandom_range(0, 1));
      av = $urandom & ((32'h1 << w) - 32'h1);
      bv = $urandom & ((32'h1 << w) - 32'h1);
      model(w, mode, av, bv, er, eco, eov);
      run_check(w, $sformatf("rnd%0d_w%0d_%0h_%s_%0h", n, w, av, mode ? "+" : "-", bv),
                mode, av, bv, er, eco, eov);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
